array_feeder: RTL and testbench

ARRAY_FEEDER -- requirements
Module: array_feeder

---
 rtl/array_feeder_pkg.sv | 15 +
 rtl/array_feeder.sv | 82 ++++++++
 tb/tb_array_feeder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/array_feeder_pkg.sv
// Shared constants and state encoding for the skewed array feeder and its memory.
package array_feeder_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned LINES      = 4;
    localparam int unsigned ELEM_BITS  = 2;
    localparam logic [2:0]  LAST_STEP  = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } feeder_state_e;

endpackage

// File: rtl/array_feeder.sv
// Feeds a 4x4 memory into a systolic array edge as a diagonal wavefront:
// column c is read at step t with element t-c, and the read data is registered one cycle later.
module array_feeder #(
    parameter int unsigned DATA_WIDTH = array_feeder_pkg::DATA_WIDTH,
    parameter int unsigned LINES      = array_feeder_pkg::LINES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          hold,
    output logic [LINES-1:0]              read_enable,
    output logic [2*LINES-1:0]            read_elem,
    input  logic [LINES*DATA_WIDTH-1:0]   mem_data,
    output logic [LINES*DATA_WIDTH-1:0]   array_data,
    output logic [LINES-1:0]              array_valid,
    output logic                          busy,
    output logic                          done
);
    import array_feeder_pkg::*;

    feeder_state_e state_q, state_d;
    logic [2:0]    t_q, t_d;

    logic                        issue;
    logic [LINES*DATA_WIDTH-1:0] array_data_d;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    t_d     = 3'd0;
                end
            end
            StRun: begin
                if (!hold) begin
                    if (t_q == LAST_STEP) begin
                        state_d = StDrain;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reads are gated by rst so the memory sees no strobe while reset is held.
    assign issue = (state_q == StRun) && !hold && !rst;

    for (genvar c = 0; c < LINES; c++) begin : g_skew
        logic [3:0] lag;
        // Negative lags wrap to large values and fall outside the 0..3 window.
        assign lag = {1'b0, t_q} - 4'(c);
        assign read_enable[c] = issue && (lag < 4'd4);
        assign read_elem[ELEM_BITS*c +: ELEM_BITS] = read_enable[c] ? lag[1:0] : 2'b00;
        assign array_data_d[c*DATA_WIDTH +: DATA_WIDTH] =
            read_enable[c] ? mem_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            t_q         <= 3'd0;
            array_data  <= '0;
            array_valid <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            array_data  <= array_data_d;
            array_valid <= read_enable;
        end
    end

    // The DRAIN cycle is exactly when the final column-3 element sits on array_data.
    assign busy = !rst && (state_q != StIdle);
    assign done = !rst && (state_q == StDrain);

endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder with a step-level reference model checked every cycle.
module tb_array_feeder;
    import array_feeder_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       hold;
    logic [3:0]                 read_enable;
    logic [7:0]                 read_elem;
    logic [4*DATA_WIDTH-1:0]    mem_data;
    logic [4*DATA_WIDTH-1:0]    array_data;
    logic [3:0]                 array_valid;
    logic                       busy;
    logic                       done;

    int checks = 0;
    int errors = 0;

    logic [DATA_WIDTH-1:0] mem [4][4];

    array_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold        (hold),
        .read_enable (read_enable),
        .read_elem   (read_elem),
        .mem_data    (mem_data),
        .array_data  (array_data),
        .array_valid (array_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Asynchronous-read memory, addressed per column by the element field.
    always_comb begin
        mem_data = '0;
        for (int c = 0; c < 4; c++) begin
            mem_data[c*DATA_WIDTH +: DATA_WIDTH] = mem[c][read_elem[2*c +: 2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: step -1 is idle, 0..6 are wavefront steps, 7 is the drain cycle.
    function automatic logic [3:0] exp_en(input int step, input logic h, input logic r);
        exp_en = 4'b0000;
        if (!r && !h && step >= 0 && step <= 6) begin
            for (int c = 0; c < 4; c++) begin
                if (step - c >= 0 && step - c <= 3) exp_en[c] = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] exp_elem(input int step, input logic h, input logic r);
        logic [3:0] en;
        en       = exp_en(step, h, r);
        exp_elem = 8'h00;
        for (int c = 0; c < 4; c++) begin
            if (en[c]) exp_elem[2*c +: 2] = 2'(step - c);
        end
    endfunction

    function automatic logic [31:0] exp_data(input int step, input logic h, input logic r);
        logic [3:0] en;
        en       = exp_en(step, h, r);
        exp_data = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (en[c]) exp_data[c*8 +: 8] = 8'(16 * c + (step - c));
        end
    endfunction

    int          m_step  = -1;
    bit          m_known = 1'b0;
    logic [3:0]  m_valid = 4'b0000;
    logic [31:0] m_data  = 32'h0;

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            if (rst) begin
                m_known = 1'b1;
                m_step  = -1;
                m_valid = 4'b0000;
                m_data  = 32'h0;
            end else if (m_known) begin
                m_valid = exp_en(m_step, hold, rst);
                m_data  = exp_data(m_step, hold, rst);
                if (m_step < 0) begin
                    if (start) m_step = 0;
                end else if (m_step == 7) begin
                    m_step = -1;
                end else if (!hold) begin
                    m_step = m_step + 1;
                end
            end
            @(negedge clk);
            if (m_known) begin
                chk("cyc_read_enable", read_enable, exp_en(m_step, hold, rst));
                chk("cyc_read_elem", read_elem, exp_elem(m_step, hold, rst));
                chk("cyc_busy", busy, !rst && m_step >= 0);
                chk("cyc_done", done, !rst && m_step == 7);
                chk("cyc_array_valid", array_valid, m_valid);
                chk("cyc_array_data", array_data, m_data);
            end
        end
    end

    task automatic basic_feed();
        logic [3:0]  v   [8];
        logic [3:0]  en  [8];
        logic [7:0]  el  [8];
        logic [31:0] dat [8];
        logic        dn  [8];
        logic [3:0]  seq [7];
        int          dcnt;
        seq  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        dcnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v[k]   = array_valid;
            en[k]  = read_enable;
            el[k]  = read_elem;
            dat[k] = array_data;
            dn[k]  = done;
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("basic_first_enable", en[0], 4'b0001);
        for (int k = 1; k < 8; k++) chk("basic_valid_seq", v[k], seq[k-1]);
        chk("basic_step3_data", dat[4], 32'h30211203);
        chk("basic_t5_enable", en[5], 4'b1100);
        chk("basic_t5_elem", el[5], 8'b10_11_00_00);
        chk("basic_done_last", dn[7], 1'b1);
        chk("basic_done_valid", v[7], 4'b1000);
        chk("basic_done_count", dcnt, 1);
        @(negedge clk);
        chk("basic_back_idle", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_feed(input int hold_at, input int hold_len, input int start_at,
                            input int rst_at, output int busy_cyc, output int done_cnt,
                            output int zero_valid);
        bit ended;
        ended      = 1'b0;
        busy_cyc   = 0;
        done_cnt   = 0;
        zero_valid = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hold  = (i >= hold_at) && (i < hold_at + hold_len);
            start = (i == start_at);
            rst   = (i == rst_at);
            @(negedge clk);
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            busy_cyc++;
            if (done) done_cnt++;
            if (i > 0 && array_valid == 4'b0000) zero_valid++;
            @(posedge clk); #1;
        end
        hold  = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("feed_ended", ended, 1'b1);
    endtask

    task automatic back_to_back();
        int  dcnt;
        int  last;
        bit  idle_seen;
        dcnt = 0;
        last = -1;
        idle_seen = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (last >= 0) chk("b2b_done_gap", i - last, 9);
                last = i;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("b2b_done_count", dcnt, 3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("b2b_returns_idle", idle_seen, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int b, d, z;
        for (int c = 0; c < 4; c++) begin
            for (int e = 0; e < 4; e++) mem[c][e] = 8'(16 * c + e);
        end
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_read_enable", read_enable, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", array_valid, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", array_data, 32'h0);
        chk("reset_done", done, 1'b0);
        @(posedge clk); #1;

        basic_feed();

        run_feed(2, 2, -1, -1, b, d, z);
        chk("hold_busy_cycles", b, 10);
        chk("hold_done_count", d, 1);
        chk("hold_bubbles", z, 2);

        run_feed(-1, 0, 4, -1, b, d, z);
        chk("restart_busy_cycles", b, 8);
        chk("restart_done_count", d, 1);

        run_feed(-1, 0, -1, 3, b, d, z);
        chk("abort_busy_cycles", b, 3);
        chk("abort_done_count", d, 0);
        @(negedge clk);
        chk("abort_valid", array_valid, 4'b0000);
        chk("abort_data", array_data, 32'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_read_enable", read_enable, 4'b0000);
        @(posedge clk); #1;

        basic_feed();
        back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
